// File: rtl/dataout_buf_param.sv
// Packet-injection source: streams NUM_PKT packets of PKT_LEN flits
// from a write-loaded memory with valid/ready, pause and loop modes.
module dataout_buf_param #(
  parameter int DATA_W  = 20,
  parameter int PKT_LEN = 6,
  parameter int NUM_PKT = 5,
  parameter int ADDR_W  = 5,
  parameter int LOOP    = 0
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              enable,
  input  logic              clear,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              out_valid,
  output logic              out_head,
  output logic              out_tail,
  output logic              busy,
  output logic              done,
  output logic [15:0]       flit_cnt
);

  localparam int DEPTH = PKT_LEN * NUM_PKT;
  localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W+1:0] fifo [2];

  logic [ADDR_W-1:0] rd_addr;
  logic [CW-1:0]     col;
  logic              reads_done;
  logic              wp, rp;
  logic [1:0]        cnt;

  logic issue, pop, final_pop, wr_ok, start;

  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign start     = (state == IDLE) && enable;

  // A read lands in the FIFO on the next edge, so a pop frees a slot.
  assign issue = (state == RUN) && !reads_done &&
                 ((cnt < 2'd2) || pop);

  assign final_pop = (LOOP == 0) && reads_done &&
                     pop && (cnt == 2'd1);

  assign wr_ok = wr_en &&
                 ((state == IDLE) || (state == DONE)) &&
                 (32'(wr_addr) < 32'(DEPTH));

  assign {out_head, out_tail, dataout} =
    out_valid ? fifo[rp] : '0;

  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (enable) state_n = RUN;
      RUN: begin
        if (final_pop)    state_n = DONE;
        else if (!enable) state_n = PAUSE;
      end
      PAUSE: begin
        if (final_pop)   state_n = DONE;
        else if (enable) state_n = RUN;
      end
      DONE:  if (clear) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= IDLE;
      rd_addr    <= '0;
      col        <= '0;
      reads_done <= 1'b0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      cnt        <= 2'd0;
      flit_cnt   <= 16'd0;
    end else begin
      state <= state_n;
      if (start) begin
        rd_addr    <= '0;
        col        <= '0;
        reads_done <= 1'b0;
        flit_cnt   <= 16'd0;
      end else begin
        if (issue) begin
          col <= (col == COL_LAST) ? '0 : col + 1'b1;
          if (rd_addr == LAST) begin
            rd_addr    <= '0;
            reads_done <= (LOOP == 0);
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        if (pop && (flit_cnt != 16'hFFFF))
          flit_cnt <= flit_cnt + 16'd1;
      end
      if (issue) wp <= ~wp;
      if (pop)   rp <= ~rp;
      unique case ({issue, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage only; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    if (issue)
      fifo[wp] <= {col == '0, col == COL_LAST, mem[rd_addr]};
  end

endmodule

// File: tb/tb_dataout_buf_param.sv
// Scoreboard bench for dataout_buf_param: default instance plus a
// small looping instance, checked against an address-level model.
module tb_dataout_buf_param;

  typedef struct {
    logic [19:0] d;
    logic        h;
    logic        t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_we, a_en, a_clr, a_ready;
  logic [4:0]  a_waddr;
  logic [19:0] a_wdata, a_dout;
  logic        a_valid, a_head, a_tail, a_busy, a_done;
  logic [15:0] a_cnt;

  logic        b_rst, b_we, b_en, b_clr, b_ready;
  logic [2:0]  b_waddr;
  logic [19:0] b_wdata, b_dout;
  logic        b_valid, b_head, b_tail, b_busy, b_done;
  logic [15:0] b_cnt;

  dataout_buf_param u_a (
    .clk(clk), .RST(a_rst), .wr_en(a_we),
    .wr_addr(a_waddr), .wr_data(a_wdata),
    .enable(a_en), .clear(a_clr), .out_ready(a_ready),
    .dataout(a_dout), .out_valid(a_valid),
    .out_head(a_head), .out_tail(a_tail),
    .busy(a_busy), .done(a_done), .flit_cnt(a_cnt)
  );

  dataout_buf_param #(
    .DATA_W(20), .PKT_LEN(4), .NUM_PKT(2),
    .ADDR_W(3), .LOOP(1)
  ) u_b (
    .clk(clk), .RST(b_rst), .wr_en(b_we),
    .wr_addr(b_waddr), .wr_data(b_wdata),
    .enable(b_en), .clear(b_clr), .out_ready(b_ready),
    .dataout(b_dout), .out_valid(b_valid),
    .out_head(b_head), .out_tail(b_tail),
    .busy(b_busy), .done(b_done), .flit_cnt(b_cnt)
  );

  int vec = 0;
  int errs = 0;
  int ha = 0;
  int hb = 0;
  bit bp = 1'b0;
  logic [19:0] mem_a [30];
  logic [19:0] mem_b [8];
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bp) a_ready = 1'($urandom_range(0, 1));
  endtask

  // Address-level model: flit i of the image.
  task automatic push_a();
    for (int i = 0; i < 30; i++)
      qa.push_back('{d: mem_a[i], h: (i % 6 == 0),
                     t: (i % 6 == 5)});
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!a_done && n < 300) begin
      step();
      n++;
    end
    chk(nm, 32'(a_done), 1);
  endtask

  task automatic clear_a();
    a_en = 1'b0;
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    chk("clr_done", 32'(a_done), 0);
  endtask

  exp_t ea, eb;
  logic pa_v = 1'b0, pa_r = 1'b0, pa_rst = 1'b0;
  logic [21:0] pa_o = '0;
  logic pb_v = 1'b0, pb_r = 1'b0;
  logic [21:0] pb_o = '0;

  always @(negedge clk) begin
    if (pa_v && !pa_r && !pa_rst) begin
      chk("a_hold_v", 32'(a_valid), 1);
      chk("a_hold_d", 32'({a_head, a_tail, a_dout}), 32'(pa_o));
    end
    if (a_valid && a_ready) begin
      if (qa.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL a_extra: got flit %0h expected none", a_dout);
      end else begin
        ea = qa.pop_front();
        chk("a_data", 32'(a_dout), 32'(ea.d));
        chk("a_head", 32'(a_head), 32'(ea.h));
        chk("a_tail", 32'(a_tail), 32'(ea.t));
      end
      ha++;
    end
    pa_v = a_valid;
    pa_r = a_ready;
    pa_rst = a_rst;
    pa_o = {a_head, a_tail, a_dout};
  end

  always @(negedge clk) begin
    if (pb_v && !pb_r) begin
      chk("b_hold_v", 32'(b_valid), 1);
      chk("b_hold_d", 32'({b_head, b_tail, b_dout}), 32'(pb_o));
    end
    if (b_valid && b_ready) begin
      if (qb.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL b_extra: got flit %0h expected none", b_dout);
      end else begin
        eb = qb.pop_front();
        chk("b_data", 32'(b_dout), 32'(eb.d));
        chk("b_head", 32'(b_head), 32'(eb.h));
        chk("b_tail", 32'(b_tail), 32'(eb.t));
      end
      hb++;
    end
    pb_v = b_valid;
    pb_r = b_ready;
    pb_o = {b_head, b_tail, b_dout};
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, base, h0;
    a_rst = 1; a_we = 0; a_en = 0; a_clr = 0; a_ready = 0;
    a_waddr = '0; a_wdata = '0;
    b_rst = 1; b_we = 0; b_en = 0; b_clr = 0; b_ready = 0;
    b_waddr = '0; b_wdata = '0;
    step();
    step();
    a_rst = 0;
    b_rst = 0;
    step();
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_cnt", 32'(a_cnt), 0);
    chk("rst_dout", 32'(a_dout), 0);
    chk("rst_b_cnt", 32'(b_cnt), 0);

    // Load image; out-of-range writes must be dropped.
    for (int i = 0; i < 32; i++) begin
      a_we = 1'b1;
      a_waddr = 5'(i);
      a_wdata = (i < 30) ? 20'(i + 'h100) : 20'hFFFFF;
      if (i < 30) mem_a[i] = 20'(i + 'h100);
      step();
    end
    a_we = 1'b0;

    // 1: contiguous stream, fixed latency
    a_ready = 1'b1;
    push_a();
    a_en = 1'b1;
    step();
    chk("lat_c1", 32'(a_valid), 0);
    step();
    for (int k = 0; k < 30; k++) begin
      chk("contig", 32'(a_valid), 1);
      step();
    end
    chk("t1_done", 32'(a_done), 1);
    chk("t1_busy", 32'(a_busy), 0);
    chk("t1_cnt", 32'(a_cnt), 30);
    chk("t1_q", 32'(qa.size()), 0);
    clear_a();

    // 2: random backpressure
    bp = 1'b1;
    push_a();
    a_en = 1'b1;
    wait_done("t2_done");
    chk("t2_cnt", 32'(a_cnt), 30);
    chk("t2_q", 32'(qa.size()), 0);
    bp = 1'b0;
    a_ready = 1'b1;
    clear_a();

    // 3: pause after the 10th handshake
    push_a();
    base = ha;
    a_en = 1'b1;
    n = 0;
    while (ha - base < 10 && n < 100) begin
      step();
      n++;
    end
    a_en = 1'b0;
    h0 = ha;
    repeat (8) step();
    chk("t3_extra", 32'(ha - h0 <= 2), 1);
    chk("t3_busy", 32'(a_busy), 1);
    chk("t3_valid", 32'(a_valid), 0);
    a_en = 1'b1;
    wait_done("t3_done");
    chk("t3_cnt", 32'(a_cnt), 30);
    chk("t3_q", 32'(qa.size()), 0);
    clear_a();

    // 4: writes while running, then reset at flit 15
    push_a();
    base = ha;
    a_en = 1'b1;
    n = 0;
    while (ha - base < 5 && n < 100) begin
      step();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      a_we = 1'b1;
      a_waddr = 5'($urandom_range(0, 29));
      a_wdata = 20'($urandom);
      step();
    end
    a_we = 1'b0;
    n = 0;
    while (ha - base < 15 && n < 100) begin
      step();
      n++;
    end
    a_ready = 1'b0;
    a_rst = 1'b1;
    step();
    chk("t4_valid", 32'(a_valid), 0);
    chk("t4_head", 32'(a_head), 0);
    chk("t4_tail", 32'(a_tail), 0);
    chk("t4_busy", 32'(a_busy), 0);
    chk("t4_done", 32'(a_done), 0);
    chk("t4_cnt", 32'(a_cnt), 0);
    chk("t4_dout", 32'(a_dout), 0);
    qa.delete();
    a_rst = 1'b0;
    a_ready = 1'b1;
    push_a();
    wait_done("t4_done2");
    chk("t4_cnt2", 32'(a_cnt), 30);
    chk("t4_q", 32'(qa.size()), 0);

    // 6: enable alone in DONE is ignored; clear+enable restarts
    repeat (5) begin
      step();
      chk("t6_quiet", 32'(a_valid), 0);
      chk("t6_done", 32'(a_done), 1);
    end
    push_a();
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    chk("t6_idle_b", 32'(a_busy), 0);
    chk("t6_idle_d", 32'(a_done), 0);
    step();
    chk("t6_run", 32'(a_busy), 1);
    wait_done("t6_done2");
    chk("t6_cnt", 32'(a_cnt), 30);
    chk("t6_q", 32'(qa.size()), 0);
    a_en = 1'b0;

    // 5: loop instance, period 8
    for (int i = 0; i < 8; i++) begin
      mem_b[i] = 20'($urandom);
      b_we = 1'b1;
      b_waddr = 3'(i);
      b_wdata = mem_b[i];
      step();
    end
    b_we = 1'b0;
    for (int k = 0; k < 40; k++)
      qb.push_back('{d: mem_b[k % 8], h: (k % 4 == 0),
                     t: (k % 4 == 3)});
    b_ready = 1'b1;
    b_en = 1'b1;
    n = 0;
    while (hb < 20 && n < 100) begin
      step();
      n++;
    end
    b_ready = 1'b0;
    chk("t5_hs", 32'(hb), 20);
    chk("t5_cnt", 32'(b_cnt), 20);
    chk("t5_done", 32'(b_done), 0);
    chk("t5_busy", 32'(b_busy), 1);
    qb.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
